// File: rtl/mem_pkg.sv
// Shared response field widths, dest codes and the round-robin helper
// used by the DRAM response path.
package mem_pkg;

    localparam int ADDR_W = 32;
    localparam int OP_W   = 3;
    localparam int ID_W   = 2;

    localparam logic [ID_W-1:0] DEST_I = 2'd0;
    localparam logic [ID_W-1:0] DEST_D = 2'd1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [OP_W-1:0]   op;
        logic              flush;
        logic [ID_W-1:0]   src;
    } resp_meta_t;

    function automatic logic dest_legal(input logic [ID_W-1:0] d);
        return (d == DEST_I) || (d == DEST_D);
    endfunction

    // Returns {take_even, take_odd, rr_next}; rr=0 selects even.
    function automatic logic [2:0] rr_arb(
        input logic free,
        input logic ce,
        input logic co,
        input logic rr
    );
        logic [2:0] r;
        r = {2'b00, rr};
        if (free) begin
            if (ce && co) begin
                r = rr ? 3'b010 : 3'b101;
            end else begin
                r = {ce, co, rr};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/resp_fifo.sv
// Per-side response FIFO with registered near-full threshold
// giving one cycle of slack to the registered bank output.
module resp_fifo
    import mem_pkg::*;
#(
    parameter int CL_SIZE = 128,
    parameter int Q_DEPTH = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               push_i,
    input  resp_meta_t         meta_i,
    input  logic [ID_W-1:0]    dest_i,
    input  logic [CL_SIZE-1:0] data_i,
    input  logic               pop_i,
    output logic               head_valid_o,
    output resp_meta_t         head_meta_o,
    output logic [ID_W-1:0]    head_dest_o,
    output logic [CL_SIZE-1:0] head_data_o,
    output logic               full_thresh_o,
    output logic               ovf_o
);

    localparam int AW = $clog2(Q_DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]      wr_q, wr_d;
    logic [AW-1:0]      rd_q, rd_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               thr_q, thr_d;
    logic               full;
    logic               push_ok;
    logic               pop_ok;

    resp_meta_t         meta_q [Q_DEPTH];
    logic [ID_W-1:0]    dest_q [Q_DEPTH];
    logic [CL_SIZE-1:0] data_q [Q_DEPTH];

    // Full is judged on the current count, so a pop never frees room
    // for a push in the same edge.
    assign full    = (cnt_q == CW'(Q_DEPTH));
    assign push_ok = push_i && !full;
    assign pop_ok  = pop_i && (cnt_q != '0);

    always_comb begin
        wr_d  = wr_q + AW'(push_ok);
        rd_d  = rd_q + AW'(pop_ok);
        cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
        thr_d = (cnt_d >= CW'(Q_DEPTH - 1));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            thr_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            thr_q <= thr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            meta_q[wr_q] <= meta_i;
            dest_q[wr_q] <= dest_i;
            data_q[wr_q] <= data_i;
        end
    end

    assign head_valid_o  = (cnt_q != '0);
    assign head_meta_o   = meta_q[rd_q];
    assign head_dest_o   = dest_q[rd_q];
    assign head_data_o   = data_q[rd_q];
    assign full_thresh_o = thr_q;
    assign ovf_o         = push_i && full;

endmodule

// File: rtl/mem_resp_merge.sv
// Merges even/odd DRAM bank responses into I-side and D-side fill
// ports with per-port round-robin arbitration and drop reporting.
module mem_resp_merge
    import mem_pkg::*;
#(
    parameter int CL_SIZE = 128,
    parameter int Q_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               alloc_in_even,
    input  logic [ADDR_W-1:0]  addr_in_even,
    input  logic [CL_SIZE-1:0] data_in_even,
    input  logic [OP_W-1:0]    op_in_even,
    input  logic               flush_in_even,
    input  logic [ID_W-1:0]    src_in_even,
    input  logic [ID_W-1:0]    dest_in_even,
    output logic               full_out_even,
    input  logic               alloc_in_odd,
    input  logic [ADDR_W-1:0]  addr_in_odd,
    input  logic [CL_SIZE-1:0] data_in_odd,
    input  logic [OP_W-1:0]    op_in_odd,
    input  logic               flush_in_odd,
    input  logic [ID_W-1:0]    src_in_odd,
    input  logic [ID_W-1:0]    dest_in_odd,
    output logic               full_out_odd,
    output logic               i_valid_out,
    output logic [ADDR_W-1:0]  i_addr_out,
    output logic [CL_SIZE-1:0] i_data_out,
    output logic [OP_W-1:0]    i_op_out,
    output logic               i_flush_out,
    output logic [ID_W-1:0]    i_src_out,
    input  logic               i_stall_in,
    output logic               d_valid_out,
    output logic [ADDR_W-1:0]  d_addr_out,
    output logic [CL_SIZE-1:0] d_data_out,
    output logic [OP_W-1:0]    d_op_out,
    output logic               d_flush_out,
    output logic [ID_W-1:0]    d_src_out,
    input  logic               d_stall_in,
    output logic               drop_err
);

    resp_meta_t         ev_in_m, od_in_m;
    resp_meta_t         ev_m, od_m;
    logic [ID_W-1:0]    ev_dest, od_dest;
    logic [CL_SIZE-1:0] ev_data, od_data;
    logic               ev_v, od_v;
    logic               ev_ovf, od_ovf;
    logic               ev_ill, od_ill;
    logic               ev_pop, od_pop;

    logic               i_free, d_free;
    logic               i_take_e, i_take_o;
    logic               d_take_e, d_take_o;
    logic               rr_i_q, rr_i_d;
    logic               rr_d_q, rr_d_d;

    logic               i_valid_q, i_valid_d;
    resp_meta_t         i_meta_q, i_meta_d;
    logic [CL_SIZE-1:0] i_data_q, i_data_d;
    logic               d_valid_q, d_valid_d;
    resp_meta_t         d_meta_q, d_meta_d;
    logic [CL_SIZE-1:0] d_data_q, d_data_d;
    logic               drop_q, drop_d;

    assign ev_in_m = '{addr: addr_in_even, op: op_in_even,
                       flush: flush_in_even, src: src_in_even};
    assign od_in_m = '{addr: addr_in_odd, op: op_in_odd,
                       flush: flush_in_odd, src: src_in_odd};

    resp_fifo #(.CL_SIZE(CL_SIZE), .Q_DEPTH(Q_DEPTH)) u_fifo_even (
        .clk_i         (clk),
        .rst_i         (rst),
        .push_i        (alloc_in_even),
        .meta_i        (ev_in_m),
        .dest_i        (dest_in_even),
        .data_i        (data_in_even),
        .pop_i         (ev_pop),
        .head_valid_o  (ev_v),
        .head_meta_o   (ev_m),
        .head_dest_o   (ev_dest),
        .head_data_o   (ev_data),
        .full_thresh_o (full_out_even),
        .ovf_o         (ev_ovf)
    );

    resp_fifo #(.CL_SIZE(CL_SIZE), .Q_DEPTH(Q_DEPTH)) u_fifo_odd (
        .clk_i         (clk),
        .rst_i         (rst),
        .push_i        (alloc_in_odd),
        .meta_i        (od_in_m),
        .dest_i        (dest_in_odd),
        .data_i        (data_in_odd),
        .pop_i         (od_pop),
        .head_valid_o  (od_v),
        .head_meta_o   (od_m),
        .head_dest_o   (od_dest),
        .head_data_o   (od_data),
        .full_thresh_o (full_out_odd),
        .ovf_o         (od_ovf)
    );

    // A port is free when empty or when its current beat is accepted now.
    assign i_free = !i_valid_q || !i_stall_in;
    assign d_free = !d_valid_q || !d_stall_in;

    assign ev_ill = ev_v && !dest_legal(ev_dest);
    assign od_ill = od_v && !dest_legal(od_dest);

    always_comb begin
        {i_take_e, i_take_o, rr_i_d} = rr_arb(i_free,
            ev_v && (ev_dest == DEST_I),
            od_v && (od_dest == DEST_I), rr_i_q);
        {d_take_e, d_take_o, rr_d_d} = rr_arb(d_free,
            ev_v && (ev_dest == DEST_D),
            od_v && (od_dest == DEST_D), rr_d_q);
    end

    assign ev_pop = i_take_e || d_take_e || ev_ill;
    assign od_pop = i_take_o || d_take_o || od_ill;
    assign drop_d = ev_ovf || od_ovf || ev_ill || od_ill;

    always_comb begin
        i_valid_d = i_valid_q;
        i_meta_d  = i_meta_q;
        i_data_d  = i_data_q;
        if (i_free) begin
            i_valid_d = i_take_e || i_take_o;
        end
        if (i_take_e) begin
            i_meta_d = ev_m;
            i_data_d = ev_data;
        end else if (i_take_o) begin
            i_meta_d = od_m;
            i_data_d = od_data;
        end
    end

    always_comb begin
        d_valid_d = d_valid_q;
        d_meta_d  = d_meta_q;
        d_data_d  = d_data_q;
        if (d_free) begin
            d_valid_d = d_take_e || d_take_o;
        end
        if (d_take_e) begin
            d_meta_d = ev_m;
            d_data_d = ev_data;
        end else if (d_take_o) begin
            d_meta_d = od_m;
            d_data_d = od_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_i_q    <= 1'b0;
            rr_d_q    <= 1'b0;
            i_valid_q <= 1'b0;
            i_meta_q  <= '0;
            i_data_q  <= '0;
            d_valid_q <= 1'b0;
            d_meta_q  <= '0;
            d_data_q  <= '0;
            drop_q    <= 1'b0;
        end else begin
            rr_i_q    <= rr_i_d;
            rr_d_q    <= rr_d_d;
            i_valid_q <= i_valid_d;
            i_meta_q  <= i_meta_d;
            i_data_q  <= i_data_d;
            d_valid_q <= d_valid_d;
            d_meta_q  <= d_meta_d;
            d_data_q  <= d_data_d;
            drop_q    <= drop_d;
        end
    end

    assign i_valid_out = i_valid_q;
    assign i_addr_out  = i_meta_q.addr;
    assign i_data_out  = i_data_q;
    assign i_op_out    = i_meta_q.op;
    assign i_flush_out = i_meta_q.flush;
    assign i_src_out   = i_meta_q.src;

    assign d_valid_out = d_valid_q;
    assign d_addr_out  = d_meta_q.addr;
    assign d_data_out  = d_data_q;
    assign d_op_out    = d_meta_q.op;
    assign d_flush_out = d_meta_q.flush;
    assign d_src_out   = d_meta_q.src;

    assign drop_err = drop_q;

endmodule

// File: tb/tb_mem_resp_merge.sv
// Directed and randomized bench for mem_resp_merge with a queue-based
// reference of per-side, per-port response order.
module tb_mem_resp_merge;

    localparam int CL = 128;

    typedef struct packed {
        logic [31:0]   addr;
        logic [CL-1:0] data;
        logic [2:0]    op;
        logic          flush;
        logic [1:0]    src;
    } item_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          alloc_in_even, alloc_in_odd;
    logic [31:0]   addr_in_even, addr_in_odd;
    logic [CL-1:0] data_in_even, data_in_odd;
    logic [2:0]    op_in_even, op_in_odd;
    logic          flush_in_even, flush_in_odd;
    logic [1:0]    src_in_even, src_in_odd;
    logic [1:0]    dest_in_even, dest_in_odd;
    logic          full_out_even, full_out_odd;
    logic          i_valid_out, d_valid_out;
    logic [31:0]   i_addr_out, d_addr_out;
    logic [CL-1:0] i_data_out, d_data_out;
    logic [2:0]    i_op_out, d_op_out;
    logic          i_flush_out, d_flush_out;
    logic [1:0]    i_src_out, d_src_out;
    logic          i_stall_in, d_stall_in;
    logic          drop_err;

    int nvec = 0;
    int nerr = 0;

    // index = side*2 + port; side 0 even / 1 odd, port 0 I / 1 D
    item_t mq [4][$];

    mem_resp_merge #(.CL_SIZE(CL), .Q_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .alloc_in_even(alloc_in_even), .addr_in_even(addr_in_even),
        .data_in_even(data_in_even), .op_in_even(op_in_even),
        .flush_in_even(flush_in_even), .src_in_even(src_in_even),
        .dest_in_even(dest_in_even), .full_out_even(full_out_even),
        .alloc_in_odd(alloc_in_odd), .addr_in_odd(addr_in_odd),
        .data_in_odd(data_in_odd), .op_in_odd(op_in_odd),
        .flush_in_odd(flush_in_odd), .src_in_odd(src_in_odd),
        .dest_in_odd(dest_in_odd), .full_out_odd(full_out_odd),
        .i_valid_out(i_valid_out), .i_addr_out(i_addr_out),
        .i_data_out(i_data_out), .i_op_out(i_op_out),
        .i_flush_out(i_flush_out), .i_src_out(i_src_out),
        .i_stall_in(i_stall_in),
        .d_valid_out(d_valid_out), .d_addr_out(d_addr_out),
        .d_data_out(d_data_out), .d_op_out(d_op_out),
        .d_flush_out(d_flush_out), .d_src_out(d_src_out),
        .d_stall_in(d_stall_in),
        .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [167:0] obs,
                       input logic [167:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic item_t rnd_item();
        item_t t;
        t.addr  = $urandom;
        t.data  = {$urandom, $urandom, $urandom, $urandom};
        t.op    = 3'($urandom);
        t.flush = 1'($urandom);
        t.src   = 2'($urandom);
        return t;
    endfunction

    task automatic drv_e(input logic v, input item_t t, input logic [1:0] d);
        alloc_in_even = v;
        addr_in_even  = t.addr;
        data_in_even  = t.data;
        op_in_even    = t.op;
        flush_in_even = t.flush;
        src_in_even   = t.src;
        dest_in_even  = d;
    endtask

    task automatic drv_o(input logic v, input item_t t, input logic [1:0] d);
        alloc_in_odd = v;
        addr_in_odd  = t.addr;
        data_in_odd  = t.data;
        op_in_odd    = t.op;
        flush_in_odd = t.flush;
        src_in_odd   = t.src;
        dest_in_odd  = d;
    endtask

    function automatic item_t oi();
        return {i_addr_out, i_data_out, i_op_out, i_flush_out, i_src_out};
    endfunction

    function automatic item_t od();
        return {d_addr_out, d_data_out, d_op_out, d_flush_out, d_src_out};
    endfunction

    task automatic match(input int p, input item_t o);
        item_t exp;
        exp = '0;
        if (mq[p].size() > 0 && mq[p][0] == o) begin
            exp = mq[p].pop_front();
        end else if (mq[2+p].size() > 0 && mq[2+p][0] == o) begin
            exp = mq[2+p].pop_front();
        end else if (mq[p].size() > 0) begin
            exp = mq[p][0];
        end else if (mq[2+p].size() > 0) begin
            exp = mq[2+p][0];
        end
        chk(p == 0 ? "rand_i" : "rand_d", o, exp);
    endtask

    initial begin
        item_t a, b, c, x, y, f, g;
        item_t e [6];
        logic  hold_i, hold_d;
        item_t snap_i, snap_d;
        logic  ae, ao;
        logic  [1:0] de, dd;
        item_t ie, io;

        // reset, with allocs asserted that must be ignored
        rst = 1'b1;
        i_stall_in = 1'b0;
        d_stall_in = 1'b0;
        drv_e(1'b1, rnd_item(), 2'd0);
        drv_o(1'b1, rnd_item(), 2'd1);
        tick();
        tick();
        chk("rst_i", {i_valid_out, oi()}, '0);
        chk("rst_d", {d_valid_out, od()}, '0);
        chk("rst_flags", {full_out_even, full_out_odd, drop_err}, '0);
        rst = 1'b0;
        drv_e(1'b0, '0, 2'd0);
        drv_o(1'b0, '0, 2'd0);
        tick();
        tick();
        chk("rst_empty", {i_valid_out, d_valid_out, drop_err}, '0);

        // single response, two-cycle latency
        a = rnd_item();
        a.addr = 32'h40;
        a.data = {16{8'hA5}};
        drv_e(1'b1, a, 2'd0);
        tick();
        drv_e(1'b0, a, 2'd0);
        chk("single_lat", {i_valid_out, d_valid_out}, '0);
        tick();
        chk("single_i", {i_valid_out, oi()}, {1'b1, a});
        chk("single_d", d_valid_out, 1'b0);
        tick();
        chk("single_done", i_valid_out, 1'b0);

        // contention on D twice: even first, then odd first
        for (int r = 0; r < 2; r++) begin
            b = rnd_item();
            c = rnd_item();
            drv_e(1'b1, b, 2'd1);
            drv_o(1'b1, c, 2'd1);
            tick();
            drv_e(1'b0, b, 2'd0);
            drv_o(1'b0, c, 2'd0);
            tick();
            chk($sformatf("rr%0d_first", r), {d_valid_out, od()},
                {1'b1, (r == 0) ? b : c});
            tick();
            chk($sformatf("rr%0d_second", r), {d_valid_out, od()},
                {1'b1, (r == 0) ? c : b});
            tick();
            chk($sformatf("rr%0d_idle", r), {d_valid_out, i_valid_out}, '0);
        end

        // parallel: different ports pop in the same cycle
        x = rnd_item();
        y = rnd_item();
        drv_e(1'b1, x, 2'd0);
        drv_o(1'b1, y, 2'd1);
        tick();
        drv_e(1'b0, x, 2'd0);
        drv_o(1'b0, y, 2'd0);
        tick();
        chk("par_i", {i_valid_out, oi()}, {1'b1, x});
        chk("par_d", {d_valid_out, od()}, {1'b1, y});
        tick();
        chk("par_idle", {i_valid_out, d_valid_out}, '0);

        // backpressure: first entry sits in the stalled D reg,
        // FIFO fills to 4, the sixth alloc is dropped
        d_stall_in = 1'b1;
        for (int k = 0; k < 6; k++) e[k] = rnd_item();
        for (int k = 0; k < 4; k++) begin
            drv_e(1'b1, e[k], 2'd1);
            tick();
            if (k == 2) chk("bp_full_early", full_out_even, 1'b0);
        end
        chk("bp_full_at3", full_out_even, 1'b1);
        chk("bp_hold0", {d_valid_out, od()}, {1'b1, e[0]});
        drv_e(1'b1, e[4], 2'd1);
        tick();
        chk("bp_no_drop", {drop_err, full_out_even}, 2'b01);
        drv_e(1'b1, e[5], 2'd1);
        tick();
        chk("bp_drop", drop_err, 1'b1);
        chk("bp_hold1", {d_valid_out, od()}, {1'b1, e[0]});
        drv_e(1'b0, e[5], 2'd0);
        tick();
        chk("bp_pulse", drop_err, 1'b0);
        d_stall_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_out%0d", k), {d_valid_out, od()}, {1'b1, e[k]});
            tick();
        end
        chk("bp_drain", {d_valid_out, full_out_even}, '0);

        // illegal dest is discarded with a drop pulse
        f = rnd_item();
        drv_e(1'b1, f, 2'd3);
        tick();
        drv_e(1'b0, f, 2'd0);
        chk("ill_lat", drop_err, 1'b0);
        tick();
        chk("ill_drop", {drop_err, i_valid_out, d_valid_out}, 3'b100);
        tick();
        chk("ill_quiet", {drop_err, i_valid_out, d_valid_out}, '0);
        g = rnd_item();
        drv_e(1'b1, g, 2'd0);
        tick();
        drv_e(1'b0, g, 2'd0);
        tick();
        chk("ill_next", {i_valid_out, oi()}, {1'b1, g});
        tick();

        // reset while entries are buffered and held
        d_stall_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drv_o(1'b1, rnd_item(), 2'd1);
            tick();
        end
        drv_o(1'b0, '0, 2'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        d_stall_in = 1'b0;
        chk("midrst", {d_valid_out, full_out_odd, drop_err}, '0);
        tick();
        tick();
        chk("midrst_empty", {d_valid_out, i_valid_out}, '0);

        // randomized traffic against the queue reference
        hold_i = 1'b0;
        hold_d = 1'b0;
        snap_i = '0;
        snap_d = '0;
        for (int cyc = 0; cyc < 420; cyc++) begin
            if (hold_i) chk("hold_i", {i_valid_out, oi()}, {1'b1, snap_i});
            if (hold_d) chk("hold_d", {d_valid_out, od()}, {1'b1, snap_d});
            chk("rand_nodrop", drop_err, 1'b0);
            i_stall_in = (cyc < 400) && ($urandom_range(0, 3) == 0);
            d_stall_in = (cyc < 400) && ($urandom_range(0, 3) == 0);
            if (i_valid_out && !i_stall_in) match(0, oi());
            if (d_valid_out && !d_stall_in) match(1, od());
            hold_i = i_valid_out && i_stall_in;
            hold_d = d_valid_out && d_stall_in;
            snap_i = oi();
            snap_d = od();
            ae = (cyc < 400) && !full_out_even && ($urandom_range(0, 1) == 1);
            ao = (cyc < 400) && !full_out_odd && ($urandom_range(0, 1) == 1);
            de = 2'($urandom_range(0, 1));
            dd = 2'($urandom_range(0, 1));
            ie = rnd_item();
            io = rnd_item();
            if (ae) mq[int'(de)].push_back(ie);
            if (ao) mq[2 + int'(dd)].push_back(io);
            drv_e(ae, ie, de);
            drv_o(ao, io, dd);
            tick();
        end
        chk("rand_empty",
            mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size(), '0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
